// File: rtl/branch_predict_btb.sv
// Branch target buffer with 2-bit saturating direction counters.
//
// Lookup (combinational, reflects state as of the last clock edge):
//   pc          - fetch address; bit 0 ignored, pc[IW:1] selects the set,
//                 pc[15:IW+1] is the tag
//   hit         - tag matches a valid way in the selected set
//   bta_out     - stored target of the hitting way, 0 on miss
//   predict_out - hit and the hitting way's counter MSB
// Update (registered at the rising edge of clk):
//   upd_valid   - strobe carrying a resolved branch
//   upd_pc      - address of the resolved branch
//   upd_taken   - resolved direction
//   upd_target  - resolved target address
//   flush       - invalidate every entry (beats a simultaneous update)
//   reset       - synchronous active-high; clears valids, counters to
//                 CTR_INIT, victim pointers to 0; beats flush and update
module branch_predict_btb #(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned NUM_WAYS = 2,
  parameter logic [1:0]  CTR_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic        hit,
  output logic [15:0] bta_out,
  output logic        predict_out,
  input  logic        upd_valid,
  input  logic [15:0] upd_pc,
  input  logic        upd_taken,
  input  logic [15:0] upd_target,
  input  logic        flush
);

  localparam int unsigned IW = $clog2(NUM_SETS);
  localparam int unsigned TW = 15 - IW;
  // A single-way BTB still carries a 1-bit pointer that never leaves 0.
  localparam int unsigned WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic          valid_q [NUM_SETS][NUM_WAYS];
  logic [TW-1:0] tag_q   [NUM_SETS][NUM_WAYS];
  logic [15:0]   tgt_q   [NUM_SETS][NUM_WAYS];
  logic [1:0]    ctr_q   [NUM_SETS][NUM_WAYS];
  logic [WW-1:0] ptr_q   [NUM_SETS];

  logic [IW-1:0] lk_idx;
  logic [TW-1:0] lk_tag;
  logic [IW-1:0] up_idx;
  logic [TW-1:0] up_tag;
  logic          unused_lsb;

  assign lk_idx     = pc[IW:1];
  assign lk_tag     = pc[15:IW+1];
  assign up_idx     = upd_pc[IW:1];
  assign up_tag     = upd_pc[15:IW+1];
  assign unused_lsb = pc[0] ^ upd_pc[0];

  // Lookup: outputs are gated by valid, so unreset tags/targets never leak.
  always_comb begin
    hit         = 1'b0;
    bta_out     = '0;
    predict_out = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[lk_idx][WW'(w)] && (tag_q[lk_idx][WW'(w)] == lk_tag)) begin
        hit         = 1'b1;
        bta_out     = tgt_q[lk_idx][WW'(w)];
        predict_out = ctr_q[lk_idx][WW'(w)][1];
      end
    end
  end

  logic          up_hit;
  logic [WW-1:0] up_hway;
  logic          free_found;
  logic [WW-1:0] free_way;
  logic [WW-1:0] alloc_way;
  logic [WW-1:0] ptr_d;
  logic [1:0]    ctr_cur;
  logic [1:0]    ctr_d;

  // Update-side search: hitting way, lowest invalid way, next counter value.
  always_comb begin
    up_hit     = 1'b0;
    up_hway    = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[up_idx][WW'(w)] && (tag_q[up_idx][WW'(w)] == up_tag)) begin
        up_hit  = 1'b1;
        up_hway = WW'(w);
      end
      if (!valid_q[up_idx][WW'(w)] && !free_found) begin
        free_found = 1'b1;
        free_way   = WW'(w);
      end
    end
    alloc_way = free_found ? free_way : ptr_q[up_idx];
    ptr_d     = (ptr_q[up_idx] == WW'(NUM_WAYS - 1)) ? '0 : ptr_q[up_idx] + WW'(1);
    ctr_cur   = ctr_q[up_idx][up_hway];
    if (upd_taken) begin
      ctr_d = (ctr_cur == 2'b11) ? ctr_cur : ctr_cur + 2'd1;
    end else begin
      ctr_d = (ctr_cur == 2'b00) ? ctr_cur : ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          valid_q[IW'(s)][WW'(w)] <= 1'b0;
          ctr_q[IW'(s)][WW'(w)]   <= CTR_INIT;
        end
        ptr_q[IW'(s)] <= '0;
      end
    end else if (flush) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          valid_q[IW'(s)][WW'(w)] <= 1'b0;
        end
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_q[up_idx][up_hway] <= ctr_d;
        if (upd_taken) begin
          tgt_q[up_idx][up_hway] <= upd_target;
        end
      end else if (upd_taken) begin
        valid_q[up_idx][alloc_way] <= 1'b1;
        tag_q[up_idx][alloc_way]   <= up_tag;
        tgt_q[up_idx][alloc_way]   <= upd_target;
        ctr_q[up_idx][alloc_way]   <= CTR_INIT;
        // Pointer only moves when a valid way is evicted.
        if (!free_found) begin
          ptr_q[up_idx] <= ptr_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_btb.sv
module tb_branch_predict_btb;

  logic        clk = 1'b0;
  logic        reset, flush, upd_valid, upd_taken;
  logic [15:0] pc, upd_pc, upd_target;
  logic        hit, predict_out;
  logic [15:0] bta_out;

  int n_cmp = 0;
  int n_bad = 0;

  branch_predict_btb #(
    .NUM_SETS(8),
    .NUM_WAYS(2),
    .CTR_INIT(2'b10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .hit        (hit),
    .bta_out    (bta_out),
    .predict_out(predict_out),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (8 sets x 2 ways) ----------------
  localparam int CINIT = 2;
  bit m_v   [8][2];
  int m_tag [8][2];
  int m_tgt [8][2];
  int m_ctr [8][2];
  int m_ptr [8];

  function automatic void m_lookup(input int a, output logic [17:0] r);
    int s = (a % 16) / 2;
    int t = a / 16;
    r = '0;
    for (int i = 0; i < 2; i++)
      if (m_v[s][i] && m_tag[s][i] == t)
        r = {1'b1, 16'(m_tgt[s][i]), (m_ctr[s][i] >= 2)};
  endfunction

  function automatic void m_step(input bit rst, input bit fl, input bit uv,
                                 input int a, input bit tk, input int tg);
    int s = (a % 16) / 2;
    int t = a / 16;
    int hw = -1;
    int w = -1;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 2; j++) begin
          m_v[i][j] = 0;
          m_ctr[i][j] = CINIT;
        end
        m_ptr[i] = 0;
      end
      return;
    end
    if (fl) begin
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 2; j++) m_v[i][j] = 0;
      return;
    end
    if (!uv) return;
    for (int i = 0; i < 2; i++)
      if (m_v[s][i] && m_tag[s][i] == t) hw = i;
    if (hw >= 0) begin
      if (tk) begin
        m_ctr[s][hw] = (m_ctr[s][hw] == 3) ? 3 : m_ctr[s][hw] + 1;
        m_tgt[s][hw] = tg;
      end else begin
        m_ctr[s][hw] = (m_ctr[s][hw] == 0) ? 0 : m_ctr[s][hw] - 1;
      end
    end else if (tk) begin
      for (int i = 0; i < 2; i++)
        if (!m_v[s][i] && w < 0) w = i;
      if (w < 0) begin
        w = m_ptr[s];
        m_ptr[s] = (m_ptr[s] + 1) % 2;
      end
      m_v[s][w]   = 1;
      m_tag[s][w] = t;
      m_tgt[s][w] = tg;
      m_ctr[s][w] = CINIT;
    end
  endfunction

  // ---------------- helpers ----------------
  function automatic void check(input string nm, input logic [17:0] a, input logic [17:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got hit=%0b bta=%h pred=%0b, expected hit=%0b bta=%h pred=%0b",
               nm, a[17], a[16:1], a[0], e[17], e[16:1], e[0]);
    end
  endfunction

  // One clock cycle: drive at negedge, sample lookup 1ns later, model follows the posedge.
  task automatic cyc(input bit rst, input bit fl, input bit uv, input logic [15:0] upc,
                     input bit tk, input logic [15:0] utg, input logic [15:0] lpc,
                     output logic [17:0] act, output logic [17:0] mdl);
    @(negedge clk);
    reset = rst; flush = fl; upd_valid = uv; upd_pc = upc;
    upd_taken = tk; upd_target = utg; pc = lpc;
    #1;
    act = {hit, bta_out, predict_out};
    m_lookup(int'(lpc), mdl);
    @(posedge clk);
    m_step(rst, fl, uv, int'(upc), tk, int'(utg));
  endtask

  typedef struct {
    bit          uv;
    logic [15:0] upc;
    bit          tk;
    logic [15:0] utg;
    logic [15:0] lpc;
    bit          eh;
    logic [15:0] eb;
    bit          ep;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit uv, input logic [15:0] upc, input bit tk, input logic [15:0] utg,
                     input logic [15:0] lpc, input bit eh, input logic [15:0] eb, input bit ep);
    vec_t v;
    v.uv = uv; v.upc = upc; v.tk = tk; v.utg = utg; v.lpc = lpc;
    v.eh = eh; v.eb = eb; v.ep = ep;
    tv.push_back(v);
  endtask

  function automatic logic [15:0] rnd_pc();
    return 16'(((($urandom_range(0, 5) + 16) << 4)) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] a, m;
    logic [15:0] up, lp;
    bit r, f, u, t;

    reset = 1'b1; flush = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0;
    upd_pc = '0; upd_target = '0; pc = '0;

    // Reset state
    cyc(1, 0, 0, 16'h0, 0, 16'h0, 16'h0104, a, m);
    cyc(1, 0, 0, 16'h0, 0, 16'h0, 16'h0104, a, m);
    check("reset_hold", a, 18'h0);
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 16'h0000, a, m);
    check("after_reset", a, 18'h0);

    // Table: allocate, saturation, replacement, not-taken miss, same-cycle hazard
    add(1, 16'h0104, 1, 16'h0200, 16'h0104, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 16'h0000, 16'h0104, 1, 16'h0200, 1);
    add(1, 16'h0104, 0, 16'h0200, 16'h0104, 1, 16'h0200, 1);
    add(1, 16'h0104, 0, 16'h0200, 16'h0104, 1, 16'h0200, 0);
    add(1, 16'h0104, 0, 16'hBEEF, 16'h0104, 1, 16'h0200, 0);
    add(1, 16'h0104, 1, 16'h0200, 16'h0104, 1, 16'h0200, 0);
    add(1, 16'h0104, 1, 16'h0200, 16'h0104, 1, 16'h0200, 0);
    add(1, 16'h0104, 1, 16'h0200, 16'h0104, 1, 16'h0200, 1);
    add(1, 16'h0104, 1, 16'h0222, 16'h0104, 1, 16'h0200, 1);
    add(0, 16'h0000, 0, 16'h0000, 16'h0104, 1, 16'h0222, 1);
    add(1, 16'h0104, 0, 16'h0000, 16'h0104, 1, 16'h0222, 1);
    add(0, 16'h0000, 0, 16'h0000, 16'h0104, 1, 16'h0222, 1);
    add(1, 16'h0114, 1, 16'h1140, 16'h0114, 0, 16'h0000, 0);
    add(1, 16'h0124, 1, 16'h1240, 16'h0104, 1, 16'h0222, 1);
    add(0, 16'h0000, 0, 16'h0000, 16'h0104, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 16'h0000, 16'h0114, 1, 16'h1140, 1);
    add(1, 16'h0134, 1, 16'h1340, 16'h0124, 1, 16'h1240, 1);
    add(0, 16'h0000, 0, 16'h0000, 16'h0114, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 16'h0000, 16'h0134, 1, 16'h1340, 1);
    add(0, 16'h0000, 0, 16'h0000, 16'h0124, 1, 16'h1240, 1);
    add(1, 16'h0306, 0, 16'h3333, 16'h0306, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 16'h0000, 16'h0306, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 16'h0000, 16'h0124, 1, 16'h1240, 1);
    add(1, 16'h0108, 1, 16'h0800, 16'h0108, 0, 16'h0000, 0);
    add(0, 16'h0000, 0, 16'h0000, 16'h0108, 1, 16'h0800, 1);
    add(0, 16'h0000, 0, 16'h0000, 16'h0109, 1, 16'h0800, 1);
    add(1, 16'h0109, 1, 16'h0900, 16'h0108, 1, 16'h0800, 1);
    add(0, 16'h0000, 0, 16'h0000, 16'h0108, 1, 16'h0900, 1);

    for (int i = 0; i < tv.size(); i++) begin
      cyc(0, 0, tv[i].uv, tv[i].upc, tv[i].tk, tv[i].utg, tv[i].lpc, a, m);
      check($sformatf("vec%0d", i), a, {tv[i].eh, tv[i].eb, tv[i].ep});
    end

    // Flush beats a simultaneous taken update
    cyc(0, 1, 1, 16'h0144, 1, 16'h1440, 16'h0124, a, m); check("flush_pre", a, {1'b1, 16'h1240, 1'b1});
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 16'h0124, a, m);        check("flush_0124", a, 18'h0);
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 16'h0144, a, m);        check("flush_0144", a, 18'h0);
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 16'h0108, a, m);        check("flush_0108", a, 18'h0);

    // Reset beats flush and update; reallocation starts from CTR_INIT
    cyc(0, 0, 1, 16'h0108, 1, 16'h0808, 16'h0108, a, m); check("rs_alloc", a, 18'h0);
    cyc(0, 0, 1, 16'h0108, 0, 16'h0808, 16'h0108, a, m); check("rs_hit", a, {1'b1, 16'h0808, 1'b1});
    cyc(1, 1, 1, 16'h0150, 1, 16'h1500, 16'h0108, a, m); check("rs_pre", a, {1'b1, 16'h0808, 1'b0});
    cyc(1, 0, 0, 16'h0, 0, 16'h0, 16'h0108, a, m);        check("rs_during", a, 18'h0);
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 16'h0150, a, m);        check("rs_discard", a, 18'h0);
    cyc(0, 0, 1, 16'h0108, 1, 16'h0808, 16'h0108, a, m); check("rs_realloc", a, 18'h0);
    cyc(0, 0, 1, 16'h0108, 0, 16'h0808, 16'h0108, a, m); check("rs_init", a, {1'b1, 16'h0808, 1'b1});
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 16'h0108, a, m);        check("rs_dec", a, {1'b1, 16'h0808, 1'b0});

    // Randomized run against the model
    cyc(1, 0, 0, 16'h0, 0, 16'h0, 16'h0, a, m);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 49) == 0);
      u  = $urandom_range(0, 1);
      t  = ($urandom_range(0, 3) != 0);
      up = rnd_pc();
      lp = ($urandom_range(0, 2) == 0) ? up : rnd_pc();
      cyc(r, f, u, up, t, 16'($urandom), lp, a, m);
      check($sformatf("rand%0d", i), a, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
